// File: rtl/reduce_arbiter.sv
// reduce_arbiter: round-robin front end sharing one mod-L reducer between two requesters,
// with a watchdog that abandons a reduction that never completes.
module reduce_arbiter #(
    parameter int TIMEOUT = 1100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [511:0] din0,
    input  logic [511:0] din1,
    output logic         ack0,
    output logic         ack1,
    output logic         rsp_vld0,
    output logic         rsp_vld1,
    input  logic         rsp_rdy0,
    input  logic         rsp_rdy1,
    output logic [252:0] rsp_data,
    output logic         red_start,
    output logic [511:0] red_din,
    input  logic [252:0] red_dout,
    input  logic         red_done,
    input  logic         red_busy,
    output logic         busy,
    output logic         timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic           own_q, own_d, last_q, last_d, gnt;
    logic           start_q, start_d, tmo_q, tmo_d;
    logic [1:0]     ack_q, ack_d, vld_q, vld_d;
    logic [511:0]   buf_q, buf_d;
    logic [252:0]   data_q, data_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // A tie goes to whichever port did not win last time.
    assign gnt = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        buf_d   = buf_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ack_d   = 2'b00;
        vld_d   = 2'b00;
        start_d = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: if ((req0 || req1) && !red_busy) begin
                own_d   = gnt;
                last_d  = gnt;
                buf_d   = gnt ? din1 : din0;
                ack_d   = gnt ? 2'b10 : 2'b01;
                start_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (red_done) begin
                data_d  = red_dout;
                vld_d   = own_q ? 2'b10 : 2'b01;
                state_d = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                tmo_d   = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
            RESP: if (own_q ? rsp_rdy1 : rsp_rdy0) state_d = IDLE;
                  else vld_d = vld_q;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            buf_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 2'b00;
            vld_q   <= 2'b00;
            start_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            vld_q   <= vld_d;
            start_q <= start_d;
            tmo_q   <= tmo_d;
        end
    end

    assign ack0        = ack_q[0];
    assign ack1        = ack_q[1];
    assign rsp_vld0    = vld_q[0];
    assign rsp_vld1    = vld_q[1];
    assign rsp_data    = data_q;
    assign red_start   = start_q;
    assign red_din     = buf_q;
    assign timeout_err = tmo_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_reduce_arbiter.sv
// tb_reduce_arbiter: directed checks of reduce_arbiter against a behavioural stub reducer
// (L is the ed25519 group order, a 253-bit prime).
module tb_reduce_arbiter;
    localparam logic [511:0] L = 512'h1_0000000000_0000000000_0000000000_0_14def9dea2f79cd65812631a5cf5d3ed;

    logic         clk = 1'b0, rst = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, rsp_rdy0 = 1'b0, rsp_rdy1 = 1'b0;
    logic [511:0] din0 = '0, din1 = '0;
    logic         ack0, ack1, rsp_vld0, rsp_vld1, red_start, busy, timeout_err;
    logic [252:0] rsp_data;
    logic [511:0] red_din;
    logic [252:0] red_dout = '0;
    logic         red_done = 1'b0, red_busy, sr_busy = 1'b0;
    logic [511:0] sr_op = '0;
    int           sr_cnt = 0, sr_lat = 4;
    bit           sr_hang = 0, inj_done = 0, busy_ovr = 0;

    int n_chk = 0, n_err = 0, n_gnt = 0, hold_n = 0;
    int n_start = 0, n_vld0 = 0, n_vld1 = 0, n_tmo = 0, gcount = 0;
    logic [7:0]   gbits = '0;
    logic [252:0] rlog[$];

    reduce_arbiter #(.TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
        .ack0(ack0), .ack1(ack1), .rsp_vld0(rsp_vld0), .rsp_vld1(rsp_vld1),
        .rsp_rdy0(rsp_rdy0), .rsp_rdy1(rsp_rdy1), .rsp_data(rsp_data),
        .red_start(red_start), .red_din(red_din), .red_dout(red_dout),
        .red_done(red_done), .red_busy(red_busy), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Stub reducer: done pulse sr_lat cycles after sampling red_start, unless told to hang.
    always @(posedge clk) begin
        red_done <= inj_done;
        if (red_start) begin
            sr_op   <= red_din;
            sr_cnt  <= sr_lat;
            sr_busy <= 1'b1;
        end else if (sr_cnt > 0) begin
            sr_cnt <= sr_cnt - 1;
            if (sr_cnt == 1) begin
                red_done <= !sr_hang || inj_done;
                red_dout <= 253'(sr_op % L);
                sr_busy  <= 1'b0;
            end
        end
    end
    assign red_busy = sr_busy | busy_ovr;

    always @(negedge clk) begin
        if (red_start) n_start++;
        if (rsp_vld0) n_vld0++;
        if (rsp_vld1) n_vld1++;
        if (timeout_err) n_tmo++;
        if (ack0 || ack1) begin
            gbits = {gbits[6:0], ack1};
            gcount++;
        end
        if (rsp_vld0 || rsp_vld1) rlog.push_back(rsp_data);
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {ack0, ack1, rsp_vld0, rsp_vld1, red_start, timeout_err, busy, |rsp_data, |red_din};
    endfunction

    function automatic bit sig(input int w);
        return w == 0 ? ack0 : w == 1 ? ack1 : w == 2 ? rsp_vld0 : timeout_err;
    endfunction

    task automatic step();
        @(negedge clk);
        if (ack0 || ack1) begin
            n_gnt++;
            if (hold_n == 0) begin
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
            end else if (n_gnt >= hold_n) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
    endtask

    task automatic wait_sig(input string tag, input int w, output int c);
        c = 0;
        do begin
            step();
            c++;
        end while (!sig(w) && c < 200);
        if (!sig(w)) chk(tag, 512'(sig(w)), 512'(1));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int c, s0, g0, r0, v0, t0;
        bit ok;
        repeat (2) @(negedge clk);
        chk("reset_outs", 512'(outs()), 512'(0));
        rst = 1'b1;

        rsp_rdy0 = 1'b1; rsp_rdy1 = 1'b1;
        s0 = n_start; g0 = gcount;
        req0 = 1'b1; din0 = L + 5;
        wait_sig("vld0_single", 2, c);
        chk("latency", 512'(c), 512'(7));
        chk("data_5", 512'(rsp_data), 512'(5));
        repeat (5) step();
        chk("ack0_once", 512'(gcount - g0), 512'(1));
        chk("start_once", 512'(n_start - s0), 512'(1));
        chk("vld1_never", 512'(n_vld1), 512'(0));

        do_reset();
        g0 = gcount; r0 = rlog.size();
        req0 = 1'b1; req1 = 1'b1; din0 = 7; din1 = L + L + 9;
        repeat (40) step();
        chk("tie_grants", 512'(gcount - g0), 512'(2));
        chk("tie_order", 512'(gbits[1:0]), 512'(2'b01));
        chk("tie_res0", 512'(rlog[r0]), 512'(7));
        chk("tie_res1", 512'(rlog[r0+1]), 512'(9));

        g0 = gcount; s0 = n_start; r0 = rlog.size(); n_gnt = 0; hold_n = 4;
        req0 = 1'b1; req1 = 1'b1; din0 = 3; din1 = L + 4;
        repeat (80) step();
        hold_n = 0;
        chk("rr_grants", 512'(gcount - g0), 512'(4));
        chk("rr_order", 512'(gbits[3:0]), 512'(4'b0101));
        chk("rr_starts", 512'(n_start - s0), 512'(4));
        chk("rr_res1", 512'(rlog[r0+1]), 512'(4));

        rsp_rdy0 = 1'b0;
        req0 = 1'b1; din0 = L + L + L + 100;
        wait_sig("vld0_hold", 2, c);
        req1 = 1'b1; din1 = 11;
        ok = 1;
        repeat (10) begin
            step();
            if (!(rsp_vld0 && rsp_data == 253'd100 && !ack1 && !rsp_vld1)) ok = 0;
        end
        chk("hold_stable", 512'(ok), 512'(1));
        rsp_rdy0 = 1'b1;
        step();
        chk("idle_after_rdy", 512'({rsp_vld0, busy, ack1}), 512'(0));
        step();
        chk("ack1_next", 512'(ack1), 512'(1));
        repeat (20) step();
        chk("res_11", 512'(rlog[rlog.size()-1]), 512'(11));

        g0 = gcount;
        busy_ovr = 1; req0 = 1'b1; din0 = 5;
        repeat (4) step();
        chk("no_gnt_busy", 512'(gcount - g0), 512'(0));
        req0 = 1'b0; busy_ovr = 0;
        repeat (4) step();
        chk("withdrawn", 512'(gcount - g0), 512'(0));
        chk("idle_withdrawn", 512'(busy), 512'(0));
        busy_ovr = 1; req1 = 1'b1; din1 = 13;
        repeat (3) step();
        busy_ovr = 0;
        wait_sig("ack1_busy", 1, c);
        chk("ack_after_busy", 512'(c), 512'(1));
        repeat (15) step();

        sr_hang = 1; v0 = n_vld0;
        req0 = 1'b1; din0 = 42;
        wait_sig("ack0_tmo", 0, c);
        wait_sig("tmo_seen", 3, c);
        chk("tmo_lat", 512'(c), 512'(21));
        step();
        chk("tmo_pulse", 512'({timeout_err, busy}), 512'(0));
        chk("tmo_no_vld", 512'(n_vld0 - v0), 512'(0));
        sr_hang = 0;
        req0 = 1'b1; din0 = 42;
        wait_sig("ack_after_tmo", 0, c);
        chk("ack_after_tmo", 512'(c), 512'(1));
        wait_sig("vld_after_tmo", 2, c);
        chk("data_42", 512'(rsp_data), 512'(42));
        repeat (4) step();

        sr_lat = 19; t0 = n_tmo;
        req0 = 1'b1; din0 = L + 6;
        wait_sig("vld_edge19", 2, c);
        chk("done_beats_tmo", 512'(rsp_data), 512'(6));
        chk("no_tmo_edge19", 512'(n_tmo - t0), 512'(0));
        repeat (4) step();
        sr_lat = 20;
        req0 = 1'b1; din0 = 8;
        wait_sig("tmo_edge20", 3, c);
        v0 = n_vld0;
        repeat (6) step();
        chk("late_done_ignored", 512'(n_vld0 - v0), 512'(0));
        repeat (4) step();

        sr_lat = 10;
        req0 = 1'b1; din0 = L + 77;
        wait_sig("ack0_rst", 0, c);
        repeat (3) step();
        #2 rst = 1'b0;
        v0 = n_vld0;
        #1 chk("rst_async", 512'(outs()), 512'(0));
        @(negedge clk);
        rst = 1'b1;
        inj_done = 1;
        @(negedge clk);
        inj_done = 0;
        repeat (20) step();
        chk("no_vld_after_rst", 512'(n_vld0 - v0), 512'(0));
        sr_lat = 4;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
